// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: oversampling UART receiver that samples each bit at mid-bit
// and reports good bytes or parity/framing errors as fixed-width strobes.
module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int PULSE_LEN    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] UART_data,
    output logic       UART_data_valid,
    output logic [1:0] UART_errors,
    output logic       UART_errors_valid,
    output logic       rx_busy
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int H  = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PULSE     = CW'(PULSE_LEN);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d, dv_cnt_q, dv_cnt_d, ev_cnt_q, ev_cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sr_q, sr_d, data_q, data_d;
    logic [1:0]    err_q, err_d;
    logic          par_q, par_d, fe_q, fe_d, fin_q, fin_d;
    logic          rx_s;

    assign rx_s = sync_q[1];

    always_comb begin
        sync_d   = {sync_q[0], rx};
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        bit_d    = bit_q;
        sr_d     = sr_q;
        par_d    = par_q;
        fe_d     = fe_q;
        fin_d    = 1'b0;
        data_d   = data_q;
        err_d    = err_q;
        dv_cnt_d = (dv_cnt_q != '0) ? dv_cnt_q - 1'b1 : '0;
        ev_cnt_d = (ev_cnt_q != '0) ? ev_cnt_q - 1'b1 : '0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                par_d = 1'b0;
                if (!rx_s) state_d = START;
            end
            START: if (cnt_q == HALF_LAST) begin
                cnt_d   = '0;
                bit_d   = 3'd0;
                state_d = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt_q == BIT_LAST) begin
                cnt_d = '0;
                sr_d  = {rx_s, sr_q[7:1]};
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: if (cnt_q == BIT_LAST) begin
                cnt_d   = '0;
                par_d   = ((^sr_q) ^ rx_s) != 1'(PARITY_ODD);
                state_d = STOP;
            end
            // The stop sample is captured first; the verdict is registered one cycle later.
            STOP: if (fin_q) begin
                state_d = fe_q ? BREAK : IDLE;
                if (fe_q || par_q) begin
                    err_d    = {fe_q, par_q};
                    ev_cnt_d = PULSE;
                end else begin
                    data_d   = sr_q;
                    dv_cnt_d = PULSE;
                end
            end else if (cnt_q == BIT_LAST) begin
                cnt_d = '0;
                fe_d  = !rx_s;
                fin_d = 1'b1;
            end
            BREAK: if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sync_q   <= 2'b11;
            cnt_q    <= '0;
            bit_q    <= 3'd0;
            sr_q     <= 8'd0;
            par_q    <= 1'b0;
            fe_q     <= 1'b0;
            fin_q    <= 1'b0;
            data_q   <= 8'd0;
            err_q    <= 2'd0;
            dv_cnt_q <= '0;
            ev_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            sr_q     <= sr_d;
            par_q    <= par_d;
            fe_q     <= fe_d;
            fin_q    <= fin_d;
            data_q   <= data_d;
            err_q    <= err_d;
            dv_cnt_q <= dv_cnt_d;
            ev_cnt_q <= ev_cnt_d;
        end
    end

    assign UART_data         = data_q;
    assign UART_errors       = err_q;
    assign UART_data_valid   = dv_cnt_q != '0;
    assign UART_errors_valid = ev_cnt_q != '0;
    assign rx_busy           = state_q != IDLE;
endmodule

// File: doc/uart_rx_frontend.md
# uart_rx_frontend

UART receive front end that deserialises the asynchronous serial input into bytes and reports line errors. It sits directly upstream of the LED manager. Its byte output drives `UART_data`/`UART_data_valid`, and its error output drives `UART_errors`/`UART_errors_valid`. It runs entirely in the `clk` domain: it oversamples the line with a bit-period counter and samples each bit at mid-bit.

## Interface
- `CLKS_PER_BIT`, default 868: `clk` cycles per bit (100 MHz / 115200). Must be ≥ 8.
- `PARITY_EN`, default 1: 1 means a parity bit follows the data bits.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Ignored when `PARITY_EN`=0.
- `PULSE_LEN`, default 1: number of cycles each valid strobe is held. Must be < `CLKS_PER_BIT`/2.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `rx` in 1: serial line, idle high, asynchronous to `clk`.
- `UART_data` out 8: last good byte received.
- `UART_data_valid` out 1: strobe, high for `PULSE_LEN` cycles, marking a good byte.
- `UART_errors` out 2: bit0 = parity error, bit1 = framing error.
- `UART_errors_valid` out 1: strobe, high for `PULSE_LEN` cycles, marking a bad frame.
- `rx_busy` out 1: high in every state except IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser (reset value 1) to give `rx_s`.
- Notation: N = `CLKS_PER_BIT`, H = floor(N/2), P = `PARITY_EN`.
- Frame format: 1 start bit (0), 8 data bits sent LSB first, optional parity bit, 1 stop bit (1).
- States:
  - IDLE: goes to START when `rx_s`=0. The bit counter is cleared.
  - START: after H cycles, samples `rx_s`. If 1, the start was a glitch and the state returns to IDLE with no output. If 0, goes to DATA.
  - DATA: samples every N cycles, shifting into `data_sr[7]` (shift right). After the 8th sample, goes to PARITY if P, else STOP.
  - PARITY: samples after N cycles. Parity error = (XOR of data ^ parity bit) != `PARITY_ODD`.
  - STOP: samples after N cycles. Framing error = (sample == 0).
    - No error: goes to IDLE.
    - Framing error: goes to BREAK.
    - Parity error only: goes to IDLE.
  - BREAK: waits for `rx_s`=1, then goes to IDLE. No new frame can start while the line is held low.
- Result, registered on the cycle after the stop sample:
  - No error: `UART_data` ← `data_sr` and `UART_data_valid` is asserted. `UART_errors` keeps its last value.
  - Any error: `UART_errors` ← {framing, parity} and `UART_errors_valid` is asserted. `UART_data` is not updated.
  - The two valid strobes are never high together.
- Each strobe has its own down-counter, loaded with `PULSE_LEN`. Strobe counting does not block the FSM.
- Reset values: `UART_data`=0, `UART_errors`=0, both strobes 0, `rx_busy`=0, state IDLE, sync flops at 1.

## Timing
- `rx_s` lags `rx` by 2 cycles.
- t0 is the edge at which IDLE sees `rx_s`=0.
- Sample points:
  - Start bit at t0+H.
  - Data bit i (0..7) at t0+H+(i+1)N.
  - Parity at t0+H+9N.
  - Stop at t0+H+(9+P)N.
- Strobes rise at the stop sample + 1 and fall after `PULSE_LEN` cycles.
- Back-to-back frames: IDLE is re-entered at the stop sample + 1, so a start edge arriving half a bit after the stop sample is accepted. A pulse still in progress completes unaffected.
- Asserting `rst` mid-frame aborts immediately. No strobe is produced for the partial frame, and all outputs take their reset values asynchronously.
- A strobe in progress when `rst` is asserted is cut to 0.

## Test plan
- Bench settings: N=16, P=1, even parity, `PULSE_LEN`=1.
  - Send 8'hA5 with correct parity 0 → `UART_data`=8'hA5. `UART_data_valid` is high for exactly one cycle at t0+8+160+1. `UART_errors_valid` stays 0.
  - Send 8'h3C with the parity bit flipped → `UART_errors`=2'b01 with a 1-cycle `UART_errors_valid`. `UART_data` holds its previous value 8'hA5.
  - Send 8'h81 with stop bit 0, then hold `rx` low for 5N → `UART_errors`=2'b10 and the FSM stays in BREAK (`rx_busy`=1). Then release, send 8'h55 → good byte 8'h55.
  - Apply a 4-cycle low glitch on idle `rx` → no strobe, and `rx_busy` returns to 0 within H+3 cycles.
- Back-to-back at N=16, `PULSE_LEN`=3: send 8'hDD and 8'hD1 with no idle gap → two good strobes, each 3 cycles wide, with `UART_data` showing 8'hDD then 8'hD1.
- Reset mid-frame: assert `rst` at data bit 4 of 8'hAA, release, then send 8'hF8 → no strobe for the aborted frame and `UART_data`=8'hF8 afterwards.
